// File: rtl/rej_uniform_sampler.sv
// Rejection sampler: turns squeezed SHAKE128 blocks into N coefficients in [0, Q)
// by reading 3-byte little-endian candidates with bit 23 masked off.
module rej_uniform_sampler #(
    parameter int Q          = 8380417,
    parameter int N          = 256,
    parameter int RATE_BYTES = 168
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          blk_valid,
    input  logic [1599:0] blk_data,
    output logic          blk_req,
    output logic          coef_valid,
    output logic [22:0]   coef_data,
    output logic [7:0]    coef_idx,
    output logic          busy,
    output logic          done
);
    localparam int BUF_W   = RATE_BYTES * 8;
    localparam int TRIPLES = RATE_BYTES / 3;
    localparam int TC_W    = $clog2(TRIPLES);
    localparam int CNT_W   = $clog2(N + 1);
    localparam logic [22:0]      Q_V      = 23'(Q);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TRIPLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BLK, PARSE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TC_W-1:0]  tc_q, tc_d;
    logic [BUF_W-1:0] buf_q;
    logic             buf_load;
    logic             blk_req_d, coef_valid_d, done_d;
    logic [22:0]      coef_data_d;
    logic [7:0]       coef_idx_d;
    logic [22:0]      cand;
    logic             accept;

    // Bytes beyond the rate are capacity and never reach the sampler.
    logic unused_capacity;
    assign unused_capacity = ^blk_data[1599:BUF_W];

    assign cand   = buf_q[int'(tc_q) * 24 +: 23];
    assign accept = (cand < Q_V);
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tc_d         = tc_q;
        buf_load     = 1'b0;
        blk_req_d    = 1'b0;
        coef_valid_d = 1'b0;
        done_d       = 1'b0;
        coef_data_d  = coef_data;
        coef_idx_d   = coef_idx;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WAIT_BLK;
                    cnt_d     = '0;
                    blk_req_d = 1'b1;
                end
            end
            WAIT_BLK: begin
                if (blk_valid) begin
                    buf_load = 1'b1;
                    tc_d     = '0;
                    state_d  = PARSE;
                end
            end
            PARSE: begin
                if (accept) begin
                    coef_valid_d = 1'b1;
                    coef_data_d  = cand;
                    coef_idx_d   = cnt_q[7:0];
                    cnt_d        = cnt_q + 1'b1;
                end
                // Finishing the polynomial wins over refilling; leftover triples are dropped.
                if (accept && cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tc_q == TC_LAST) begin
                    state_d   = WAIT_BLK;
                    blk_req_d = 1'b1;
                end else begin
                    tc_d = tc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tc_q       <= '0;
            buf_q      <= '0;
            blk_req    <= 1'b0;
            coef_valid <= 1'b0;
            coef_data  <= '0;
            coef_idx   <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tc_q       <= tc_d;
            blk_req    <= blk_req_d;
            coef_valid <= coef_valid_d;
            coef_data  <= coef_data_d;
            coef_idx   <= coef_idx_d;
            done       <= done_d;
            if (buf_load) begin
                buf_q <= blk_data[BUF_W-1:0];
            end
        end
    end

endmodule

// File: doc/rej_uniform_sampler.md
REJ_UNIFORM_SAMPLER -- requirements
Module: rej_uniform_sampler

Interface
REQ-001 Parameter Q, default 8380417, modulus; candidates >= Q are rejected.
REQ-002 Parameter N, default 256, coefficients per polynomial.
REQ-003 Parameter RATE_BYTES, default 168, SHAKE128 rate bytes consumed per squeezed block.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  single-cycle pulse; begins sampling one polynomial.
REQ-007 blk_valid  input  1  blk_data holds a valid squeezed Keccak state.
REQ-008 blk_data  input  1600  Keccak state; byte k = blk_data[8k+7:8k]; only bytes 0..RATE_BYTES-1 are used.
REQ-009 blk_req  output  1  single-cycle pulse requesting the next squeezed block from the H/SHAKE stage.
REQ-010 coef_valid  output  1  coef_data/coef_idx valid this cycle.
REQ-011 coef_data  output  23  accepted coefficient, 0..Q-1.
REQ-012 coef_idx  output  8  coefficient index, 0..N-1.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  single-cycle pulse; polynomial complete.

Function
REQ-015 FSM states: IDLE, WAIT_BLK, PARSE; all outputs registered.
REQ-016 IDLE: start=1 -> WAIT_BLK, clear coefficient counter cnt to 0, pulse blk_req the following cycle.
REQ-017 Every entry into WAIT_BLK (including the first) produces exactly one blk_req pulse.
REQ-018 WAIT_BLK: blk_valid=1 -> latch bytes 0..RATE_BYTES-1 into a 1344-bit buffer, clear triple counter tc to 0, go to PARSE.
REQ-019 blk_valid is ignored in IDLE and PARSE; start is ignored while busy=1.
REQ-020 PARSE evaluates one 3-byte triple per cycle: b0,b1,b2 = buffer bytes 3tc, 3tc+1, 3tc+2.
REQ-021 Candidate t = b0 + 256*b1 + 65536*(b2 & 0x7F); bit 7 of b2 is discarded.
REQ-022 t < Q: next cycle coef_valid=1, coef_data=t, coef_idx=cnt; cnt increments; t >= Q: no output, cnt unchanged.
REQ-023 Accepting the N-th coefficient -> done=1 in the same cycle as that coef_valid, FSM to IDLE, remaining triples discarded.
REQ-024 tc = RATE_BYTES/3-1 (55) evaluated and cnt < N after it -> WAIT_BLK (blk_req pulse).
REQ-025 Throughput: 56 PARSE cycles per block maximum; no bubble between consecutive triples of a block.
REQ-026 coef_valid, blk_req, done are 0 whenever not explicitly pulsed; coef_data/coef_idx hold last value otherwise.
REQ-027 Exactly N coef_valid pulses per start, indices 0..N-1 strictly ascending without gaps.

Reset
REQ-028 rst=1 at any time (including mid-PARSE or mid-WAIT_BLK) -> state IDLE, cnt=0, tc=0, buffer cleared, all outputs 0, immediately and asynchronously.
REQ-029 After rst deasserts, the block waits for start; no blk_req or coef_valid is produced from pre-reset state.

Verification
REQ-030 Reset: assert rst mid-PARSE -> all outputs 0 same cycle; subsequent start -> one blk_req, normal run of 256 coefficients.
REQ-031 All-zero blocks: 5 blk_req pulses; 56 coef_data=0 per block for blocks 1-4, 32 in block 5; done with coef_idx=255; busy low after.
REQ-032 All-0xFF block: t=8388607 rejected for all 56 triples; zero coef_valid; next blk_req 56 PARSE cycles after latch.
REQ-033 Boundary triples: bytes (00,E0,7F) -> accepted 8380416; bytes (01,E0,7F) -> rejected (t=Q); bytes (00,00,FF) -> accepted 8323072 (MSB dropped).
REQ-034 Protocol: start pulsed while busy and blk_valid pulsed in IDLE/PARSE -> no effect on cnt, tc, buffer or output sequence.
REQ-035 Random blocks vs. reference model: coefficient sequence, blk_req count and done timing match exactly over 100 polynomials.
